// File: rtl/guess_pkg.sv
// guess_pkg: shared state encoding and key constants for the guess-number scorer.
package guess_pkg;
    typedef enum logic [2:0] {Q_ENTRY, A_ENTRY, COMPARE, RESULT, WIN} state_t;
    localparam logic [3:0] KEY_CLR_DEFAULT = 4'hC;
    localparam logic [3:0] DIGIT_MAX       = 4'd9;
endpackage

// File: rtl/digit_shift_buffer.sv
// digit_shift_buffer: DIGITS x 4-bit shift register with fill count, clear, full flag and optional duplicate hit.
// Ports: clk, rst (async, active-high); clr empties; push shifts din in; data = stored digits (newest at [0]);
//        cnt = digits stored; full = cnt==DIGITS; hit = din already stored (only when DUP_CHK=1).
module digit_shift_buffer #(
    parameter int DIGITS  = 4,
    parameter bit DUP_CHK = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic [3:0]             din,
    output logic [DIGITS-1:0][3:0] data,
    output logic [2:0]             cnt,
    output logic                   full,
    output logic                   hit
);
    logic [DIGITS-1:0][3:0] data_q, data_d;
    logic [2:0]             cnt_q, cnt_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (clr) begin
            data_d = '0;
            cnt_d  = '0;
        end else if (push) begin
            data_d = {data_q[DIGITS-2:0], din};
            cnt_d  = cnt_q + 3'd1;
        end
    end

    // Only the first cnt entries hold real digits; cleared slots read as 0 and must not match.
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < DIGITS; k++)
            if (DUP_CHK && 3'(k) < cnt_q && data_q[k] == din) hit = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data = data_q;
    assign cnt  = cnt_q;
    assign full = cnt_q == 3'(DIGITS);
endmodule

// File: rtl/guess_judge.sv
// guess_judge: collects a secret and guesses from the keypad and scores each guess serially as xAyB.
// Ports: clk, rst (async, active-high); key_valid/key_code keypad strobe and code;
//        qa_state (1 = secret entry), r_a/r_b score, show (score valid), keypadBuf (last accepted digit),
//        win (high in WIN). Macro GUESS_CNT_EN adds guess_cnt[7:0], a saturating count of scored guesses.
module guess_judge
    import guess_pkg::*;
#(
    parameter int         DIGITS  = 4,
    parameter logic [3:0] KEY_CLR = KEY_CLR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       qa_state,
    output logic [2:0] r_a,
    output logic [2:0] r_b,
    output logic       show,
    output logic [3:0] keypadBuf,
`ifdef GUESS_CNT_EN
    output logic [7:0] guess_cnt,
`endif
    output logic       win
);
    state_t                 state_q, state_d;
    logic [2:0]             i_q, i_d, j_q, j_d;
    logic [2:0]             acc_a_q, acc_a_d, acc_b_q, acc_b_d;
    logic [2:0]             r_a_q, r_a_d, r_b_q, r_b_d;
    logic                   show_q, show_d;
    logic [3:0]             kb_q, kb_d;
    logic [DIGITS-1:0][3:0] s_data, g_data;
    logic [2:0]             s_cnt, g_cnt;
    logic                   s_full, g_full, s_hit, g_hit;
    logic                   is_digit, is_clr, s_push, s_clr, g_push, g_clr;
    logic [3:0]             s_dig, g_dig;

    assign is_digit = key_valid && key_code <= DIGIT_MAX;
    assign is_clr   = key_valid && key_code == KEY_CLR;
    assign s_push   = state_q == Q_ENTRY && is_digit && !s_hit && !s_full;
    assign s_clr    = is_clr && (state_q == Q_ENTRY || state_q == WIN);
    assign g_push   = state_q == A_ENTRY && is_digit && !g_full;
    // The guess buffer is emptied on leaving RESULT so the next digit starts a fresh guess.
    assign g_clr    = state_q == RESULT || (is_clr && (state_q == A_ENTRY || state_q == WIN));

    digit_shift_buffer #(.DIGITS(DIGITS), .DUP_CHK(1'b1)) u_secret (
        .clk(clk), .rst(rst), .clr(s_clr), .push(s_push), .din(key_code),
        .data(s_data), .cnt(s_cnt), .full(s_full), .hit(s_hit)
    );

    digit_shift_buffer #(.DIGITS(DIGITS), .DUP_CHK(1'b0)) u_guess (
        .clk(clk), .rst(rst), .clr(g_clr), .push(g_push), .din(key_code),
        .data(g_data), .cnt(g_cnt), .full(g_full), .hit(g_hit)
    );

    always_comb begin
        s_dig = '0;
        g_dig = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (3'(k) == i_q) s_dig = s_data[k];
            if (3'(k) == j_q) g_dig = g_data[k];
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_a_d = acc_a_q;
        acc_b_d = acc_b_q;
        r_a_d   = r_a_q;
        r_b_d   = r_b_q;
        show_d  = show_q;
        kb_d    = (s_push || g_push) ? key_code : kb_q;
        case (state_q)
            Q_ENTRY: if (s_push && s_cnt == 3'(DIGITS-1)) state_d = A_ENTRY;
            A_ENTRY: begin
                if (g_push && g_cnt == '0) show_d = 1'b0;
                if (g_push && g_cnt == 3'(DIGITS-1)) begin
                    state_d = COMPARE;
                    i_d     = '0;
                    j_d     = '0;
                    acc_a_d = '0;
                    acc_b_d = '0;
                end
            end
            COMPARE: begin
                if (s_dig == g_dig) begin
                    acc_a_d = (i_q == j_q) ? acc_a_q + 3'd1 : acc_a_q;
                    acc_b_d = (i_q != j_q) ? acc_b_q + 3'd1 : acc_b_q;
                end
                j_d = (j_q == 3'(DIGITS-1)) ? '0 : j_q + 3'd1;
                i_d = (j_q == 3'(DIGITS-1)) ? i_q + 3'd1 : i_q;
                if (i_q == 3'(DIGITS-1) && j_q == 3'(DIGITS-1)) state_d = RESULT;
            end
            RESULT: begin
                r_a_d   = acc_a_q;
                r_b_d   = acc_b_q;
                show_d  = 1'b1;
                state_d = (acc_a_q == 3'(DIGITS)) ? WIN : A_ENTRY;
            end
            WIN: if (is_clr) begin
                state_d = Q_ENTRY;
                show_d  = 1'b0;
                r_a_d   = '0;
                r_b_d   = '0;
            end
            default: state_d = Q_ENTRY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= Q_ENTRY;
            i_q     <= '0;
            j_q     <= '0;
            acc_a_q <= '0;
            acc_b_q <= '0;
            r_a_q   <= '0;
            r_b_q   <= '0;
            show_q  <= 1'b0;
            kb_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_a_q <= acc_a_d;
            acc_b_q <= acc_b_d;
            r_a_q   <= r_a_d;
            r_b_q   <= r_b_d;
            show_q  <= show_d;
            kb_q    <= kb_d;
        end
    end

`ifdef GUESS_CNT_EN
    logic [7:0] gcnt_q, gcnt_d;

    always_comb begin
        gcnt_d = gcnt_q;
        if (state_q == RESULT && gcnt_q != 8'hFF) gcnt_d = gcnt_q + 8'd1;
        if (state_q == WIN && is_clr) gcnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) gcnt_q <= '0;
        else     gcnt_q <= gcnt_d;
    end

    assign guess_cnt = gcnt_q;
`endif

    assign qa_state  = state_q == Q_ENTRY;
    assign win       = state_q == WIN;
    assign r_a       = r_a_q;
    assign r_b       = r_b_q;
    assign show      = show_q;
    assign keypadBuf = kb_q;
endmodule

// File: tb/tb_guess_judge.sv
// tb_guess_judge: randomized and directed checks of guess_judge against a game-rule reference model.
module tb_guess_judge;
    localparam int D = 4;
    localparam logic [3:0] CLR = 4'hC;
    localparam int PQ = 0, PA = 1, PC = 2, PW = 3;

    logic       clk = 0, rst = 1, key_valid = 0;
    logic [3:0] key_code = 0;
    logic       qa_state, show, win;
    logic [2:0] r_a, r_b;
    logic [3:0] keypadBuf;
`ifdef GUESS_CNT_EN
    logic [7:0] guess_cnt;
`endif

    guess_judge #(.DIGITS(D)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .qa_state(qa_state), .r_a(r_a), .r_b(r_b), .show(show), .keypadBuf(keypadBuf),
`ifdef GUESS_CNT_EN
        .guess_cnt(guess_cnt),
`endif
        .win(win)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    int ph, m_a, m_b, m_kb, m_gcnt;
    bit m_show;
    int sec[$], gs[$];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic bit has(input int q[$], input int v);
        foreach (q[k]) if (q[k] == v) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        ph = PQ; m_a = 0; m_b = 0; m_kb = 0; m_gcnt = 0; m_show = 0;
        sec.delete(); gs.delete();
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".qa"}, qa_state, ph == PQ);
        chk({tag, ".show"}, show, m_show);
        chk({tag, ".kb"}, keypadBuf, m_kb);
        chk({tag, ".win"}, win, ph == PW);
        chk({tag, ".ra"}, r_a, m_a);
        chk({tag, ".rb"}, r_b, m_b);
    endtask

    task automatic press(input logic [3:0] k, output bit done);
        done = 0;
        @(negedge clk); key_valid = 1; key_code = k;
        @(posedge clk); #1; key_valid = 0; key_code = 0;
        if (k == CLR) begin
            if (ph == PQ) sec.delete();
            else if (ph == PA) gs.delete();
            else if (ph == PW) begin
                ph = PQ; m_show = 0; m_a = 0; m_b = 0; m_gcnt = 0;
                sec.delete(); gs.delete();
            end
        end else if (k <= 9) begin
            if (ph == PQ && !has(sec, int'(k))) begin
                sec.push_back(int'(k)); m_kb = k;
                if (sec.size() == D) ph = PA;
            end else if (ph == PA) begin
                if (gs.size() == 0) m_show = 0;
                gs.push_back(int'(k)); m_kb = k;
                if (gs.size() == D) begin ph = PC; done = 1; end
            end
        end
        check_outs($sformatf("key%0d", k));
    endtask

    task automatic score();
        int ea = 0, eb = 0, rise = 0;
        foreach (sec[x]) foreach (gs[y]) if (sec[x] == gs[y]) begin
            if (x == y) ea++; else eb++;
        end
        for (int c = 1; c <= 17; c++) begin
            if (c <= 16 && $urandom_range(0, 1)) begin
                key_valid = 1; key_code = 4'($urandom_range(0, 15));
            end
            @(posedge clk); #1; key_valid = 0; key_code = 0;
            if (show && rise == 0) rise = c;
        end
        chk("show_latency", rise, 17);
        chk("ra", r_a, ea);
        chk("rb", r_b, eb);
        chk("kb_held", keypadBuf, m_kb);
        m_a = ea; m_b = eb; m_show = 1; gs.delete();
        m_gcnt = (m_gcnt < 255) ? m_gcnt + 1 : 255;
        ph = (ea == D) ? PW : PA;
        @(posedge clk); #1;
        check_outs("post_result");
`ifdef GUESS_CNT_EN
        chk("guess_cnt", guess_cnt, m_gcnt);
`endif
    endtask

    task automatic key(input logic [3:0] k);
        bit d;
        press(k, d);
        if (d) score();
    endtask

    task automatic keys(input int q[$]);
        foreach (q[k]) key(4'(q[k]));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit d;
        model_reset();
        repeat (3) @(posedge clk);
        #1; check_outs("reset");
        @(negedge clk); rst = 0;

        keys('{1, 2, 3, 4});
        keys('{1, 2, 4, 3});
        keys('{5, 6, 7, 8});
        key(9);
        key(4'hA); key(4'hF);
        key(CLR);
        keys('{1, 2, 3, 4});
        key(5);
        key(CLR);
        keys('{1, 1, 2, 3, 4});
        keys('{1, 2, 12, 4, 3, 2, 1});
        keys('{1, 2, 3, 4});
        key(CLR);

        keys('{1, 2, 3, 4});
        keys('{5, 6, 7});
        press(8, d);
        repeat (8) @(posedge clk);
        #3 rst = 1;
        #1;
        model_reset();
        check_outs("async_rst");
        @(negedge clk); rst = 0;

        for (int g = 0; g < 4; g++) begin
            int pool[$], skeys[$];
            pool = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
            for (int n = 0; n < D; n++) begin
                int idx = $urandom_range(0, pool.size() - 1);
                skeys.push_back(pool[idx]); pool.delete(idx);
            end
            foreach (skeys[n]) begin
                if ($urandom_range(0, 2) == 0)
                    key((n > 0 && $urandom_range(0, 1)) ? 4'(skeys[0]) : 4'($urandom_range(13, 15)));
                key(4'(skeys[n]));
            end
            for (int t = 0; t < 3 && ph == PA; t++) begin
                if ($urandom_range(0, 3) == 0) begin key(4'($urandom_range(0, 9))); key(CLR); end
                for (int n = 0; n < D; n++) begin
                    if ($urandom_range(0, 5) == 0) key(4'($urandom_range(10, 11)));
                    key(4'($urandom_range(0, 9)));
                end
            end
            keys(skeys);
            key(4'($urandom_range(0, 9)));
            key(CLR);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
